// File: rtl/mul_hilo_ctrl_if.sv
// rtl/mul_hilo_ctrl_if.sv - pipeline and multiplier signal bundle for the HI/LO multiply control stage
interface mul_hilo_ctrl_if;
    logic        start;
    logic        is_signed;
    logic [31:0] x;
    logic [31:0] y;
    logic        flush;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_prod;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    modport master (
        output start, is_signed, x, y, flush, mthi, mtlo, wdata, mul_prod,
        input  mul_a, mul_b, hi, lo, busy, done
    );

    modport slave (
        input  start, is_signed, x, y, flush, mthi, mtlo, wdata, mul_prod,
        output mul_a, mul_b, hi, lo, busy, done
    );
endinterface

// File: rtl/mul_hilo_ctrl.sv
// rtl/mul_hilo_ctrl.sv - sequential MULT/MULTU control around a combinational unsigned multiplier, with HI/LO registers
module mul_hilo_ctrl (
    input  logic               clk,
    input  logic               rst_n,
    mul_hilo_ctrl_if.slave     bus
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_NEG, S_WB} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_mul_a;
    logic [31:0] r_mul_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [63:0] r_prod;
    logic [63:0] r_res;
    logic        r_neg;
    logic        r_done;
    logic        w_idle;
    logic        w_accept;
    logic        w_commit;
    logic [31:0] w_mag_x;
    logic [31:0] w_mag_y;

    assign w_idle   = (r_state == S_IDLE);
    assign w_accept = w_idle & bus.start;
    assign w_commit = (r_state == S_WB) & ~bus.flush;

    // 0x80000000 negates to itself, which is the correct unsigned magnitude 2^31
    assign w_mag_x = (bus.is_signed && bus.x[31]) ? (~bus.x + 32'd1) : bus.x;
    assign w_mag_y = (bus.is_signed && bus.y[31]) ? (~bus.y + 32'd1) : bus.y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = bus.start ? S_MUL : S_IDLE;
            S_MUL:   w_next = bus.flush ? S_IDLE : S_NEG;
            S_NEG:   w_next = bus.flush ? S_IDLE : S_WB;
            S_WB:    w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mul_a <= 32'd0;
            r_mul_b <= 32'd0;
            r_neg   <= 1'b0;
            r_prod  <= 64'd0;
            r_res   <= 64'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_commit;
            if (w_accept) begin
                r_mul_a <= w_mag_x;
                r_mul_b <= w_mag_y;
                r_neg   <= bus.is_signed & (bus.x[31] ^ bus.y[31]);
            end
            if (r_state == S_MUL) begin
                r_prod <= bus.mul_prod;
            end
            if (r_state == S_NEG) begin
                r_res <= r_neg ? (~r_prod + 64'd1) : r_prod;
            end
            // A start in the same idle cycle takes priority and drops the moves
            if (w_idle && !bus.start) begin
                if (bus.mthi) begin
                    r_hi <= bus.wdata;
                end
                if (bus.mtlo) begin
                    r_lo <= bus.wdata;
                end
            end
            if (w_commit) begin
                r_hi <= r_res[63:32];
                r_lo <= r_res[31:0];
            end
        end
    end

    assign bus.mul_a = r_mul_a;
    assign bus.mul_b = r_mul_b;
    assign bus.hi    = r_hi;
    assign bus.lo    = r_lo;
    assign bus.busy  = ~w_idle;
    assign bus.done  = r_done;
endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// tb/tb_mul_hilo_ctrl.sv - directed self-checking bench for mul_hilo_ctrl
module tb_mul_hilo_ctrl;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    mul_hilo_ctrl_if bus ();

    mul_hilo_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.mul_prod = {32'd0, bus.mul_a} * {32'd0, bus.mul_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.x         = 32'd0;
        bus.y         = 32'd0;
        bus.flush     = 1'b0;
        bus.mthi      = 1'b0;
        bus.mtlo      = 1'b0;
        bus.wdata     = 32'd0;
    endtask

    // Issues one operation; poke drives a stray start/mthi/mtlo while busy.
    task automatic mul_op(input string tag, input logic sgn, input logic [31:0] xv,
                          input logic [31:0] yv, input logic [31:0] ea, input logic [31:0] eb,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic poke);
        bus.start     = 1'b1;
        bus.is_signed = sgn;
        bus.x         = xv;
        bus.y         = yv;
        step();
        idle_inputs();
        chk({tag, "_busy_k"}, 64'(bus.busy), 64'd1);
        chk({tag, "_done_k"}, 64'(bus.done), 64'd0);
        chk({tag, "_mul_a"},  64'(bus.mul_a), 64'(ea));
        chk({tag, "_mul_b"},  64'(bus.mul_b), 64'(eb));
        if (poke) begin
            bus.start     = 1'b1;
            bus.is_signed = 1'b0;
            bus.x         = 32'd7;
            bus.y         = 32'd9;
            bus.mthi      = 1'b1;
            bus.mtlo      = 1'b1;
            bus.wdata     = 32'hDEADBEEF;
        end
        step();
        idle_inputs();
        step();
        chk({tag, "_done_k2"}, 64'(bus.done), 64'd0);
        chk({tag, "_busy_k2"}, 64'(bus.busy), 64'd1);
        step();
        chk({tag, "_done"}, 64'(bus.done), 64'd1);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_hi"},   64'(bus.hi),   64'(ehi));
        chk({tag, "_lo"},   64'(bus.lo),   64'(elo));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        idle_inputs();
        #2;
        chk("rst_hi",    64'(bus.hi),    64'd0);
        chk("rst_lo",    64'(bus.lo),    64'd0);
        chk("rst_mul_a", 64'(bus.mul_a), 64'd0);
        chk("rst_mul_b", 64'(bus.mul_b), 64'd0);
        chk("rst_busy",  64'(bus.busy),  64'd0);
        chk("rst_done",  64'(bus.done),  64'd0);
        #10;
        rst_n = 1'b1;
        step();

        bus.mthi  = 1'b1;
        bus.wdata = 32'h12345678;
        step();
        idle_inputs();
        chk("mthi_hi", 64'(bus.hi), 64'h12345678);
        chk("mthi_lo", 64'(bus.lo), 64'd0);

        mul_op("multu_ff", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'hFFFFFFFE, 32'h00000001, 1'b0);
        mul_op("mult_m2x3", 1'b1, 32'hFFFFFFFE, 32'd3, 32'd2, 32'd3,
               32'hFFFFFFFF, 32'hFFFFFFFA, 1'b1);
        mul_op("mult_min", 1'b1, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000,
               32'h40000000, 32'h00000000, 1'b0);
        mul_op("mult_zero", 1'b1, 32'd0, 32'hFFFFFFFF, 32'd0, 32'd1,
               32'd0, 32'd0, 1'b0);
        step();
        chk("done_clear", 64'(bus.done), 64'd0);

        bus.mtlo  = 1'b1;
        bus.wdata = 32'h55;
        mul_op("start_mtlo", 1'b0, 32'd3, 32'd4, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);

        step();
        bus.mthi  = 1'b1;
        bus.wdata = 32'hA;
        step();
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b1;
        bus.wdata = 32'hB;
        step();
        idle_inputs();
        chk("pre_hi", 64'(bus.hi), 64'hA);
        chk("pre_lo", 64'(bus.lo), 64'hB);
        bus.start = 1'b1;
        bus.x     = 32'd5;
        bus.y     = 32'd7;
        step();
        idle_inputs();
        step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("flush_busy", 64'(bus.busy), 64'd0);
        chk("flush_done", 64'(bus.done), 64'd0);
        chk("flush_hi",   64'(bus.hi),   64'hA);
        chk("flush_lo",   64'(bus.lo),   64'hB);
        step();
        chk("flush_done2", 64'(bus.done), 64'd0);
        mul_op("restart", 1'b0, 32'd5, 32'd7, 32'd5, 32'd7, 32'd0, 32'd35, 1'b0);

        step();
        bus.start = 1'b1;
        bus.x     = 32'd9;
        bus.y     = 32'd9;
        step();
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_hi",   64'(bus.hi),   64'd0);
        chk("arst_lo",   64'(bus.lo),   64'd0);
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_done", 64'(bus.done), 64'd0);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("arst_nodone", 64'(bus.done), 64'd0);
        end
        chk("arst_hi_end", 64'(bus.hi), 64'd0);
        chk("arst_lo_end", 64'(bus.lo), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
